// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, scan codes
// and the bit layout of the keyboard status word.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    // Prefix bytes
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // Tracked scan codes (arrows are E0-extended, space is not)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // keyboard_data bit positions
    localparam int unsigned KB_EXT   = 8;
    localparam int unsigned KB_BRK   = 9;
    localparam int unsigned KB_FERR  = 10;
    localparam int unsigned KB_OVR   = 11;
    localparam int unsigned KB_UP    = 16;
    localparam int unsigned KB_DOWN  = 17;
    localparam int unsigned KB_LEFT  = 18;
    localparam int unsigned KB_RIGHT = 19;
    localparam int unsigned KB_SPACE = 20;
    localparam int unsigned KB_VALID = 31;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for ps2_clk/ps2_data plus a ps2_clk falling-edge
// detector. All flops reset to the idle-bus level so reset never fakes an edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_edge,
    output logic data_sync
);

    logic [2:0] clk_sr_q, clk_sr_d;
    logic [1:0] dat_sr_q, dat_sr_d;

    // Next-state of the synchronizer shift chains
    always_comb begin
        clk_sr_d = {clk_sr_q[1:0], ps2_clk};
        dat_sr_d = {dat_sr_q[0], ps2_data};
    end

    // Synchronizer registers, idle-high on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sr_q <= '1;
            dat_sr_q <= '1;
        end else begin
            clk_sr_q <= clk_sr_d;
            dat_sr_q <= dat_sr_d;
        end
    end

    // Edge when the delayed copy is high and the synchronized copy is low
    always_comb begin
        fall_edge = clk_sr_q[2] & ~clk_sr_q[1];
        data_sync = dat_sr_q[1];
    end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words, decodes E0/F0 prefixes and
// maintains a key status word with held-key bits and sticky error flags.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int bus            = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    input  logic           key_ack,
    output logic [bus-1:0] keyboard_data
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic fall_edge;
    logic data_s;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall_edge(fall_edge),
        .data_sync(data_s)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             extp_q, extp_d;
    logic             brkp_q, brkp_d;
    logic [31:0]      word_q, word_d;
    logic             frame_done;
    logic             frame_good;

    // Frame FSM, timeout, prefix tracking and status-word update
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        extp_d     = extp_q;
        brkp_d     = brkp_q;
        word_d     = word_q;
        frame_done = 1'b0;
        frame_good = 1'b0;

        if (key_ack) begin
            word_d[KB_VALID] = 1'b0;
            word_d[KB_FERR]  = 1'b0;
            word_d[KB_OVR]   = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fall_edge && !data_s) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    shift_d = {data_s, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                    frame_good = (^{shift_q, par_q}) & data_s;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-edge watchdog; a stalled frame is silently dropped
        if (state_q != ST_IDLE) begin
            if (fall_edge) begin
                tmo_d = '0;
            end else if (tmo_q >= TMO_LAST) begin
                tmo_d   = '0;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (frame_done) begin
            if (!frame_good) begin
                word_d[KB_FERR] = 1'b1;
                extp_d = 1'b0;
                brkp_d = 1'b0;
            end else if (shift_q == PFX_EXT) begin
                extp_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
                brkp_d = 1'b1;
            end else begin
                // Event wins over a coincident ack; overrun only if not acked
                word_d[7:0]     = shift_q;
                word_d[KB_EXT]  = extp_q;
                word_d[KB_BRK]  = brkp_q;
                if (word_q[KB_VALID] && !key_ack) word_d[KB_OVR] = 1'b1;
                word_d[KB_VALID] = 1'b1;
                if (extp_q) begin
                    if (shift_q == SC_UP)    word_d[KB_UP]    = ~brkp_q;
                    if (shift_q == SC_DOWN)  word_d[KB_DOWN]  = ~brkp_q;
                    if (shift_q == SC_LEFT)  word_d[KB_LEFT]  = ~brkp_q;
                    if (shift_q == SC_RIGHT) word_d[KB_RIGHT] = ~brkp_q;
                end else if (shift_q == SC_SPACE) begin
                    word_d[KB_SPACE] = ~brkp_q;
                end
                extp_d = 1'b0;
                brkp_d = 1'b0;
            end
        end
    end

    // All receiver state registers, reset has top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            extp_q  <= 1'b0;
            brkp_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            extp_q  <= extp_d;
            brkp_q  <= brkp_d;
            word_q  <= word_d;
        end
    end

    // Status word placed in the low 32 bits of the output bus
    always_comb begin
        keyboard_data       = '0;
        keyboard_data[31:0] = word_q;
    end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: directed scenarios plus
// randomized frames compared against a behavioural key-status model.
module tb_ps2_keyboard_receiver;

    localparam int TMO  = 300;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        key_ack = 1'b0;
    logic [31:0] keyboard_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the status word
    logic [7:0] m_code;
    logic       m_ext, m_brk, m_ferr, m_ovr, m_valid;
    logic       m_up, m_down, m_left, m_right, m_space;
    logic       m_extp, m_brkp;

    ps2_keyboard_receiver #(.bus(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_ack      (key_ack),
        .keyboard_data(keyboard_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w = 32'd0;
        w[7:0] = m_code;
        w[8]   = m_ext;
        w[9]   = m_brk;
        w[10]  = m_ferr;
        w[11]  = m_ovr;
        w[16]  = m_up;
        w[17]  = m_down;
        w[18]  = m_left;
        w[19]  = m_right;
        w[20]  = m_space;
        w[31]  = m_valid;
        return w;
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_ext = 0; m_brk = 0; m_ferr = 0; m_ovr = 0; m_valid = 0;
        m_up = 0; m_down = 0; m_left = 0; m_right = 0; m_space = 0;
        m_extp = 0; m_brkp = 0;
    endtask

    task automatic model_ack();
        m_valid = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good, input bit ack);
        bit was_valid;
        was_valid = m_valid;
        if (ack) model_ack();
        if (!good) begin
            m_ferr = 1; m_extp = 0; m_brkp = 0;
        end else if (b == 8'hE0) begin
            m_extp = 1;
        end else if (b == 8'hF0) begin
            m_brkp = 1;
        end else begin
            m_code = b; m_ext = m_extp; m_brk = m_brkp;
            if (was_valid && !ack) m_ovr = 1;
            m_valid = 1;
            if (m_extp) begin
                case (b)
                    8'h75: m_up    = !m_brkp;
                    8'h72: m_down  = !m_brkp;
                    8'h6B: m_left  = !m_brkp;
                    8'h74: m_right = !m_brkp;
                    default: ;
                endcase
            end else if (b == 8'h29) begin
                m_space = !m_brkp;
            end
            m_extp = 0; m_brkp = 0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; checks the word is still old just before the update cycle
    // and new one clk later, optionally pulsing key_ack on the completion cycle
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit ack, input string tag);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_pre"}, keyboard_data, exp_word());
        if (ack) key_ack = 1'b1;
        model_frame(b, !bad_par, ack);
        @(negedge clk);
        key_ack = 1'b0;
        check_eq({tag, "_post"}, keyboard_data, exp_word());
        repeat (HALF - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pulse_ack(input string tag);
        key_ack = 1'b1;
        model_ack();
        @(negedge clk);
        key_ack = 1'b0;
        @(negedge clk);
        check_eq(tag, keyboard_data, exp_word());
    endtask

    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'hE0, 8'hF0};

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_state", keyboard_data, 32'h0);

        // Plain space make
        send_frame(8'h29, 0, 0, "space_make");
        check_eq("space_bits", keyboard_data & 32'h8010_03FF, 32'h8010_0029);
        pulse_ack("ack1");

        // Extended up make then extended break
        send_frame(8'hE0, 0, 0, "e0_a");
        send_frame(8'h75, 0, 0, "up_make");
        check_eq("up_held", {31'd0, keyboard_data[16]} | {31'd0, keyboard_data[8]} << 1, 32'd3);
        send_frame(8'hE0, 0, 0, "e0_b");
        send_frame(8'hF0, 0, 0, "f0_b");
        send_frame(8'h75, 0, 0, "up_break");
        pulse_ack("ack2");

        // Bad parity then a good frame
        send_frame(8'h1C, 1, 0, "bad_par");
        check_eq("ferr_set", {31'd0, keyboard_data[10]}, 32'd1);
        send_frame(8'h1C, 0, 0, "good_1c");
        pulse_ack("ack3");

        // Stalled frame is dropped without error
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 10) @(negedge clk);
        check_eq("timeout_word", keyboard_data, exp_word());
        send_frame(8'h1C, 0, 0, "after_tmo");

        // Overrun, then ack coinciding with a completion
        pulse_ack("ack4");
        send_frame(8'h1C, 0, 0, "ovr_1");
        send_frame(8'h29, 0, 0, "ovr_2");
        check_eq("ovr_set", {31'd0, keyboard_data[11]}, 32'd1);
        send_frame(8'h72, 0, 1, "ack_on_evt");

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("mid_reset", keyboard_data, 32'h0);
        send_frame(8'h29, 0, 0, "post_reset");

        // Randomized frames and acks
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit bad, ack;
            if ($urandom_range(0, 9) == 0) b = 8'($urandom());
            else b = pool[$urandom_range(0, 9)];
            bad = ($urandom_range(0, 7) == 0);
            ack = ($urandom_range(0, 3) == 0);
            send_frame(b, bad, ack, $sformatf("rnd%0d_%h", n, b));
            if ($urandom_range(0, 4) == 0) pulse_ack($sformatf("rnd_ack%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_receiver.md
PS2_KEYBOARD_RECEIVER -- requirements
Module: ps2_keyboard_receiver

Interface
REQ-001 Parameter: bus, default 32, width of keyboard_data.
REQ-002 Parameter: TIMEOUT_CYCLES, default 100000, clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 clk  input  1  system clock, the single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  asynchronous PS/2 clock from the keyboard.
REQ-006 ps2_data  input  1  asynchronous PS/2 data from the keyboard.
REQ-007 key_ack  input  1  one-cycle strobe; the processor has consumed the pending event.
REQ-008 keyboard_data  output  bus  key status word consumed by the Frogger system keyboard_data input.

Function
REQ-009 The block SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect a ps2_clk falling edge from a third flop.
REQ-010 The block SHALL sample synchronized ps2_data only on a detected falling edge.
REQ-011 FSM states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE -> DATA on a falling edge with data=0 (start bit); data=1 SHALL keep IDLE.
REQ-013 DATA: shift 8 bits LSB first; -> PARITY after the 8th bit (3-bit counter, wraps 7->0).
REQ-014 PARITY -> STOP on the next edge, latching the parity bit.
REQ-015 STOP -> IDLE on the next edge; the frame is good if ones(data,parity) is odd and stop=1.
REQ-016 In DATA/PARITY/STOP, a timeout counter SHALL reset on each edge; reaching TIMEOUT_CYCLES SHALL return to IDLE, discarding the frame with no error flag.
REQ-017 Good byte 0xE0 SHALL set ext_pending; good byte 0xF0 SHALL set brk_pending; neither SHALL update keyboard_data.
REQ-018 Any other good byte completes an event: code, ext and break SHALL be written from the byte and the pending flags, valid SHALL be set, and both pending flags SHALL be cleared.
REQ-019 keyboard_data bit map:
- [7:0] code
- [8] ext
- [9] break
- [10] frame_err (sticky)
- [11] overrun (sticky)
- [16] up (E0 75)
- [17] down (E0 72)
- [18] left (E0 6B)
- [19] right (E0 74)
- [20] space (29)
- [31] valid
- all other bits 0.
REQ-020 Held bits [20:16] SHALL set on a matching make event and clear on the matching break event.
REQ-021 Update latency: keyboard_data SHALL change on the clk edge after the cycle in which the stop-bit falling edge is detected.
REQ-022 A bad frame SHALL set frame_err, clear both pending flags, and leave [9:0] and valid unchanged.
REQ-023 An event completing while valid=1 SHALL overwrite the fields and set overrun.
REQ-024 key_ack SHALL clear valid, frame_err and overrun.
REQ-025 When key_ack coincides with event completion, the event SHALL win: valid=1 with the new fields; frame_err and overrun SHALL clear.
REQ-026 When key_ack coincides with a bad-frame detection, frame_err SHALL end at 1.

Reset
REQ-027 reset SHALL force IDLE, clear the shift register, bit counter, timeout counter and pending flags, and set keyboard_data=0.
REQ-028 The synchronizer flops SHALL reset to 1 (bus idle), so reset mid-frame never creates a false edge.
REQ-029 reset SHALL take priority over every other input, including mid-frame.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state enum, the prefix constants 0xE0/0xF0, the five scan codes, and the keyboard_data bit positions.
REQ-031 Sub-module ps2_sync_edge SHALL contain the synchronizers and the falling-edge detector.

Verification
REQ-032 Frame 0x29, parity 0, stop 1 -> [7:0]=0x29, [9:8]=0, [20]=1, [31]=1 one clk after the stop edge.
REQ-033 Frames E0 (p0), 75 (p0), then E0, F0 (p1), 75 -> after the 2nd byte [16]=1, [8]=1; after the 5th [7:0]=0x75, [9]=1, [16]=0.
REQ-034 Frame 0x1C with parity 1 -> [10]=1, [7:0] and [31] unchanged; a following good 0x1C gives [7:0]=0x1C.
REQ-035 Start plus 4 bits, then idle for TIMEOUT_CYCLES+10 -> state IDLE, [10]=0; the next 0x1C frame decodes correctly.
REQ-036 Two events with no ack -> [11]=1. key_ack on the completion cycle of a third event -> [31]=1, [11]=0.
REQ-037 reset asserted after the 5th data bit -> keyboard_data=0; the following 0x29 frame decodes per REQ-032.
